// File: rtl/fp_align_shifter.sv
// Pipelined alignment right-shifter for the FPU add path.
// The mantissa is extended by three bits (guard, round, sticky) and shifted
// right. Every bit that falls off the bottom is folded into the sticky
// position. The logarithmic shift layers are spread across the pipeline
// slots. All slots advance together under a single valid/ready stall.
module fp_align_shifter #(
  parameter int WIDTH       = 25,
  parameter int SHIFT_W     = 8,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   fraction,
  input  logic [SHIFT_W-1:0] shift_amount,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               guard,
  output logic               round,
  output logic               sticky,
  output logic [TAG_W-1:0]   out_tag
);

  // Extended datapath width and the number of shift layers needed to cover
  // every distance that still leaves something above the sticky position.
  localparam int EW = WIDTH + 3;
  localparam int LW = $clog2(EW);

  logic                   advance;
  logic [31:0]            shift_ext;
  logic                   big_shift;
  logic [EW-1:0]          entry_data;
  logic [LW-1:0]          entry_shamt;

  logic [PIPE_STAGES-1:0] valid_q;
  logic [PIPE_STAGES-1:0] valid_d;
  logic [EW-1:0]          data_q  [PIPE_STAGES];
  logic [EW-1:0]          data_d  [PIPE_STAGES];
  logic [LW-1:0]          shamt_q [PIPE_STAGES];
  logic [LW-1:0]          shamt_d [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
  logic [TAG_W-1:0]       tag_d   [PIPE_STAGES];

  // Apply the shift layers that belong to one pipeline stage. Layer k shifts
  // by 2^k and ORs the dropped bits into bit 0. Because the running sticky
  // bit is itself dropped and re-ORed by later layers, the layered result
  // equals a single shift with full sticky accumulation.
  function automatic logic [EW-1:0] shift_layers(input logic [EW-1:0] e,
                                                 input logic [LW-1:0] sh,
                                                 input int            stage);
    logic [EW-1:0] r;
    logic [EW-1:0] lost_mask;
    logic          lost;
    r         = e;
    lost_mask = '0;
    lost      = 1'b0;
    for (int k = 0; k < LW; k++) begin
      if (((k * PIPE_STAGES) / LW) == stage && sh[k]) begin
        lost_mask = (EW'(1) << (1 << k)) - EW'(1);
        lost      = |(r & lost_mask);
        r         = r >> (1 << k);
        r[0]      = r[0] | lost;
      end
    end
    return r;
  endfunction

  // The whole pipe moves only when the output slot is empty or being taken.
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Any distance at or beyond the extended width leaves only sticky. It is
  // resolved up front, so the layers only ever see distances below EW.
  assign shift_ext   = 32'(shift_amount);
  assign big_shift   = shift_ext >= 32'(EW);
  assign entry_data  = big_shift ? {{(EW-1){1'b0}}, |fraction} : {fraction, 3'b000};
  assign entry_shamt = big_shift ? '0 : shift_ext[LW-1:0];

  // Next-slot contents: stage 0 is fed from the input, the others from
  // their predecessor. Flush kills every incoming valid bit.
  always_comb begin
    valid_d = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      data_d[i]  = '0;
      shamt_d[i] = '0;
      tag_d[i]   = '0;
    end
    valid_d[0] = in_valid & ~flush;
    data_d[0]  = shift_layers(entry_data, entry_shamt, 0);
    shamt_d[0] = entry_shamt;
    tag_d[0]   = in_tag;
    for (int i = 1; i < PIPE_STAGES; i++) begin
      valid_d[i] = valid_q[i-1] & ~flush;
      data_d[i]  = shift_layers(data_q[i-1], shamt_q[i-1], i);
      shamt_d[i] = shamt_q[i-1];
      tag_d[i]   = tag_q[i-1];
    end
  end

  // Slot valid bits: updated on advance, and also cleared by flush while stalled.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (advance || flush) begin
      valid_q <= valid_d;
    end
  end

  // Slot payloads: move together on advance, and hold for the whole stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i]  <= '0;
        shamt_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else if (advance) begin
      for (int i = 0; i < PIPE_STAGES; i++) begin
        data_q[i]  <= data_d[i];
        shamt_q[i] <= shamt_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  assign out_valid = valid_q[PIPE_STAGES-1];
  assign result    = data_q[PIPE_STAGES-1][EW-1:3];
  assign guard     = data_q[PIPE_STAGES-1][2];
  assign round     = data_q[PIPE_STAGES-1][1];
  assign sticky    = data_q[PIPE_STAGES-1][0];
  assign out_tag   = tag_q[PIPE_STAGES-1];

endmodule

// File: tb/tb_fp_align_shifter.sv
// Bench for fp_align_shifter: directed GRS and boundary cases, a full sweep,
// randomized traffic with stalls and flushes, backpressure, flush and reset.
module tb_fp_align_shifter;
  localparam int WIDTH       = 25;
  localparam int SHIFT_W     = 8;
  localparam int PIPE_STAGES = 2;
  localparam int TAG_W       = 4;

  logic               CLK = 1'b0;
  logic               nRST = 1'b1;
  logic               flush = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   fraction = '0;
  logic [SHIFT_W-1:0] shift_amount = '0;
  logic [TAG_W-1:0]   in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [WIDTH-1:0]   result;
  logic               guard, round, sticky;
  logic [TAG_W-1:0]   out_tag;

  typedef struct {
    logic [WIDTH+2:0] grs;
    logic [TAG_W-1:0] tag;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  int               vectors = 0;
  int               miscompares = 0;
  int               cyc = 0;
  logic [TAG_W-1:0] tag_ctr = 4'h5;

  fp_align_shifter #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W), .PIPE_STAGES(PIPE_STAGES), .TAG_W(TAG_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .fraction(fraction), .shift_amount(shift_amount), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .guard(guard), .round(round), .sticky(sticky), .out_tag(out_tag)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain wide arithmetic on the extended mantissa.
  function automatic logic [WIDTH+2:0] ref_shift(input logic [WIDTH-1:0] f, input int s);
    logic [63:0] e, kept, lost;
    e = 64'(f) << 3;
    if (s >= WIDTH + 3) return {{(WIDTH+2){1'b0}}, |f};
    kept = e >> s;
    lost = (s == 0) ? 64'd0 : (e & ((64'd1 << s) - 64'd1));
    return {kept[WIDTH+2:1], kept[0] | (lost != 64'd0)};
  endfunction

  // Drive one cycle of input; record the expectation if the DUT takes it.
  task automatic drive(input bit v, input logic [WIDTH-1:0] f, input int s);
    exp_t e;
    in_valid     = v;
    fraction     = f;
    shift_amount = SHIFT_W'(s);
    in_tag       = tag_ctr;
    if (v && in_ready && !flush) begin
      e.grs = ref_shift(f, int'(shift_amount));
      e.tag = tag_ctr;
      e.cyc = cyc;
      exp_q.push_back(e);
      tag_ctr = tag_ctr + 1'b1;
    end
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #1 nRST = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_init out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    vectors++;
    if ({result, guard, round, sticky, out_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_init_data got %h expected 0", {result, guard, round, sticky, out_tag});
    end
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    out_ready = 1'b1;
    #1;
    drive(1'b1, 25'h1ABCDEF, 0);
    @(negedge CLK); #1;
    drive(1'b1, 25'h0F0F0F0, 1);
    @(negedge CLK); #1;
    drive(1'b0, '0, 0);
    #2 nRST = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid out_valid=%b expected 0", out_valid);
    end
    vectors++;
    if ({result, guard, round, sticky, out_tag} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_data got %h expected 0", {result, guard, round, sticky, out_tag});
    end
    exp_q.delete();
    @(negedge CLK);
    nRST = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_after c=%0d out_valid=%b in_ready=%b expected 0/1", c, out_valid, in_ready);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_basic();
    logic [WIDTH-1:0] fr [11] = '{25'h000000F, 25'h0000007, 25'h1000000, 25'h1000000, 25'h1000000,
                                  25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000, 25'h0000000, 25'h1000000};
    int               sh [11] = '{3, 2, 1, 24, 25, 26, 27, 28, 255, 255, 0};
    logic [WIDTH+2:0] ex [11] = '{{25'h1, 3'b111}, {25'h1, 3'b110}, {25'h0800000, 3'b000},
                                  {25'h1, 3'b000}, {25'h0, 3'b100}, {25'h0, 3'b010},
                                  {25'h0, 3'b001}, {25'h0, 3'b001}, {25'h0, 3'b001},
                                  {25'h0, 3'b000}, {25'h1000000, 3'b000}};
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      #1;
      drive(1'b1, fr[i], sh[i]);
      @(negedge CLK); #1;
      drive(1'b0, '0, 0);
      for (int k = 0; k < 8 && !out_valid; k++) begin
        @(negedge CLK); #1;
      end
      vectors++;
      if (!out_valid) begin
        miscompares++;
        $display("FAIL basic_timeout case=%0d out_valid=0 expected 1", i);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL basic_extra case=%0d output with none pending", i);
      end else begin
        e = exp_q.pop_front();
        if ({result, guard, round, sticky} !== ex[i] || out_tag !== e.tag) begin
          miscompares++;
          $display("FAIL basic case=%0d got %h/%b%b%b tag %0d expected %h/%b tag %0d", i,
                   result, guard, round, sticky, out_tag, ex[i][WIDTH+2:3], ex[i][2:0], e.tag);
        end
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_sweep();
    exp_t e;
    int   n;
    n = 32 * 230;
    flush = 1'b0;
    for (int c = 0; c < n + 10; c++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL sweep_extra got tag %0d expected none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({result, guard, round, sticky, out_tag} !== {e.grs, e.tag}) begin
            miscompares++;
            $display("FAIL sweep_data got %h/%b%b%b tag %0d expected %h/%b tag %0d",
                     result, guard, round, sticky, out_tag, e.grs[WIDTH+2:3], e.grs[2:0], e.tag);
          end
          if (cyc - e.cyc != PIPE_STAGES) begin
            miscompares++;
            $display("FAIL sweep_latency got %0d expected %0d", cyc - e.cyc, PIPE_STAGES);
          end
        end
      end
      if (c < n) drive(1'b1, WIDTH'(c / 230) << 20, c % 230);
      else drive(1'b0, '0, 0);
      @(negedge CLK);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL sweep_lost got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    exp_t e;
    int   s;
    for (int c = 0; c < 1520; c++) begin
      out_ready = ($urandom_range(3) != 0);
      flush     = (c < 1500) && ($urandom_range(63) == 0);
      #1;
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL random_extra got tag %0d expected none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({result, guard, round, sticky, out_tag} !== {e.grs, e.tag}) begin
            miscompares++;
            $display("FAIL random_data got %h/%b%b%b tag %0d expected %h/%b tag %0d",
                     result, guard, round, sticky, out_tag, e.grs[WIDTH+2:3], e.grs[2:0], e.tag);
          end
        end
      end
      if (flush) exp_q.delete();
      s = ($urandom_range(2) == 0) ? int'($urandom_range(255)) : int'($urandom_range(30));
      if (c < 1500) drive($urandom_range(3) != 0, WIDTH'($urandom), s);
      else drive(1'b0, '0, 0);
      @(negedge CLK);
    end
    flush = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      #1;
      if (out_valid) begin
        vectors++;
        e = exp_q.pop_front();
        if ({result, guard, round, sticky, out_tag} !== {e.grs, e.tag}) begin
          miscompares++;
          $display("FAIL random_drain got %h tag %0d expected %h tag %0d",
                   {result, guard, round, sticky}, out_tag, e.grs, e.tag);
        end
      end
      @(negedge CLK);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL random_lost got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    exp_t                     e;
    logic [WIDTH+2+TAG_W:0]   held;
    held  = '0;
    flush = 1'b0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 4 && c <= 8);
      #1;
      if (c >= 4 && c <= 8) begin
        vectors++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_stall c=%0d in_ready=%b out_valid=%b expected 0/1", c, in_ready, out_valid);
        end
        if (c == 4) held = {result, guard, round, sticky, out_tag};
        else begin
          vectors++;
          if ({result, guard, round, sticky, out_tag} !== held) begin
            miscompares++;
            $display("FAIL bp_hold c=%0d got %h expected %h", c, {result, guard, round, sticky, out_tag}, held);
          end
        end
      end
      if (c >= 9 && c <= 18) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_rate c=%0d out_valid=%b expected 1", c, out_valid);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra got tag %0d expected none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({result, guard, round, sticky, out_tag} !== {e.grs, e.tag}) begin
            miscompares++;
            $display("FAIL bp_data got %h tag %0d expected %h tag %0d",
                     {result, guard, round, sticky}, out_tag, e.grs, e.tag);
          end
        end
      end
      drive(c < 19, WIDTH'($urandom), int'($urandom_range(40)));
      @(negedge CLK);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL bp_lost got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_flush();
    exp_t e;
    out_ready = 1'b1;
    for (int c = 0; c < 16; c++) begin
      flush = (c == PIPE_STAGES);
      #1;
      if (c > PIPE_STAGES && c <= PIPE_STAGES + 4) begin
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_valid c=%0d out_valid=%b tag %0d expected 0", c, out_valid, out_tag);
        end
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL flush_extra got tag %0d expected none", out_tag);
        end else begin
          e = exp_q.pop_front();
          if ({result, guard, round, sticky, out_tag} !== {e.grs, e.tag}) begin
            miscompares++;
            $display("FAIL flush_data got %h tag %0d expected %h tag %0d",
                     {result, guard, round, sticky}, out_tag, e.grs, e.tag);
          end
          if (cyc - e.cyc != PIPE_STAGES) begin
            miscompares++;
            $display("FAIL flush_latency got %0d expected %0d", cyc - e.cyc, PIPE_STAGES);
          end
        end
      end
      if (flush) exp_q.delete();
      drive((c <= PIPE_STAGES) || (c == PIPE_STAGES + 5), WIDTH'($urandom), int'($urandom_range(30)));
      @(negedge CLK);
    end
    flush = 1'b0;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL flush_lost got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_backpressure();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
